// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: PC ownership, inst_ram reads, 2-entry decode buffer.
// Optional ADDR_ALIGN_CHK_EN: misaligned redirects trap to EXC_VECTOR and pulse exc_adel.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_W     = 10,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0380
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              id_ready,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_pcplus4,
    output logic              exc_adel
);

    typedef enum logic {S_BOOT, S_RUN} state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc;
    logic        inflight;
    logic [31:0] tag_pc;
    logic        tag_epoch;
    logic        epoch;
    logic [31:0] buf_pc    [2];
    logic [31:0] buf_instr [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count, count_nxt;

    logic        ret_ok, pop, pop_buf, push;
    logic [31:0] head_pc, head_instr, target;

    // A returning word is visible to decode in its arrival cycle; it only
    // occupies a buffer slot if decode does not take it straight away.
    assign ret_ok   = inflight && (tag_epoch == epoch) && !redirect_valid;
    assign if_valid = (count != 2'd0) || ret_ok;
    assign pop      = if_valid && id_ready;
    assign pop_buf  = pop && (count != 2'd0);
    assign push     = ret_ok && !(pop && (count == 2'd0));

    always_comb begin
        head_pc    = tag_pc;
        head_instr = imem_rdata;
        if (count != 2'd0) begin
            head_pc    = buf_pc[rd_ptr];
            head_instr = buf_instr[rd_ptr];
        end
    end

    assign if_pc      = if_valid ? head_pc : 32'h0;
    assign if_instr   = if_valid ? head_instr : 32'h0;
    assign if_pcplus4 = if_valid ? head_pc + 32'd4 : 32'h0;
    assign imem_addr  = fetch_pc[ADDR_W+1:2];
    assign count_nxt  = count + {1'b0, push} - {1'b0, pop_buf};

    always_comb begin
        state_nxt = state;
        imem_en   = 1'b0;
        unique case (state)
            S_BOOT: state_nxt = S_RUN;
            S_RUN: imem_en = !redirect_valid &&
                             (({1'b0, count} + {2'b0, inflight}) < 3'd2);
            default: state_nxt = S_BOOT;
        endcase
    end

`ifdef ADDR_ALIGN_CHK_EN
    logic misaligned;
    logic exc_q;
    assign misaligned = redirect_pc[1:0] != 2'b00;
    assign target     = misaligned ? EXC_VECTOR : redirect_pc;
    assign exc_adel   = exc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) exc_q <= 1'b0;
        else      exc_q <= redirect_valid && misaligned;
    end
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign target          = {redirect_pc[31:2], 2'b00};
    assign exc_adel        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_BOOT;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc  <= RESET_PC;
            inflight  <= 1'b0;
            tag_pc    <= 32'h0;
            tag_epoch <= 1'b0;
            epoch     <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_pc[i]    <= 32'h0;
                buf_instr[i] <= 32'h0;
            end
        end else begin
            assert (!(count == 2'd2 && inflight));
            if (redirect_valid) begin
                fetch_pc <= target;
                inflight <= 1'b0;
                epoch    <= ~epoch;
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
                count    <= 2'd0;
            end else begin
                if (push) begin
                    buf_pc[wr_ptr]    <= tag_pc;
                    buf_instr[wr_ptr] <= imem_rdata;
                    wr_ptr            <= ~wr_ptr;
                end
                if (pop_buf) rd_ptr <= ~rd_ptr;
                count    <= count_nxt;
                inflight <= imem_en;
                if (imem_en) begin
                    tag_pc    <= fetch_pc;
                    tag_epoch <= epoch;
                    fetch_pc  <= fetch_pc + 32'd4;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios then random traffic,
// compared every cycle against a queue-based fetch model.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pcplus4;
    logic        exc_adel;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic [31:0] q[$];
    logic        ret_v;
    logic [31:0] ret_pc;
    logic        boot;
    logic [31:0] fpc;
    logic        exc_pend;

    if_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pcplus4     (if_pcplus4),
        .exc_adel       (exc_adel)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [9:0] a);
        return {6'h2A, a, 6'h15, a};
    endfunction

    always_ff @(posedge clk) begin
        if (imem_en) imem_rdata <= memf(imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ret_v    = 1'b0;
        ret_pc   = 32'h0;
        boot     = 1'b1;
        fpc      = 32'h0;
        exc_pend = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pcplus4", if_pcplus4, 32'h0);
        chk("rst_imem_en", {31'b0, imem_en}, 32'h0);
        chk("rst_exc_adel", {31'b0, exc_adel}, 32'h0);
    endtask

    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic [31:0] av[$];
        logic        ev;
        logic [31:0] epc;
        logic        en;
        logic        mis;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        av = q;
        if (ret_v && !rv) av.push_back(ret_pc);
        ev  = av.size() != 0;
        epc = ev ? av[0] : 32'h0;
        en  = !boot && !rv && ((q.size() + int'(ret_v)) < 2);
        @(negedge clk);
        chk("if_valid", {31'b0, if_valid}, {31'b0, ev});
        chk("if_pc", if_pc, epc);
        chk("if_pcplus4", if_pcplus4, ev ? epc + 32'd4 : 32'h0);
        chk("if_instr", if_instr, ev ? memf(epc[11:2]) : 32'h0);
        chk("imem_en", {31'b0, imem_en}, {31'b0, en});
        if (en) chk("imem_addr", {22'b0, imem_addr}, {22'b0, fpc[11:2]});
        chk("exc_adel", {31'b0, exc_adel}, {31'b0, exc_pend});
        @(posedge clk);
        if (ev && rdy) void'(av.pop_front());
        exc_pend = 1'b0;
        if (rv) begin
            q.delete();
            ret_v = 1'b0;
            mis   = rpc[1:0] != 2'b00;
`ifdef ADDR_ALIGN_CHK_EN
            fpc      = mis ? 32'h0000_0380 : rpc;
            exc_pend = mis;
`else
            fpc = {rpc[31:2], 2'b00};
`endif
        end else begin
            q      = av;
            ret_v  = en;
            ret_pc = fpc;
            if (en) fpc = fpc + 32'd4;
        end
        boot = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] rpc;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        rst            = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_reset_outputs();
        end
        @(posedge clk);
        #1 rst = 1'b1;

        // sequential fetch, then a decode stall and release
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

        // redirect with a read in flight
        step(1'b1, 32'h0000_0040, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

        // redirect while decode pops the buffer head
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0100, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);

        // top-of-address-space wrap, back-to-back redirects, misaligned target
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_0200, 1'b1);
        step(1'b1, 32'h0000_0300, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_0042, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

        // reset in the middle of a read
        step(1'b0, 32'h0, 1'b1);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       rpc = 32'hFFFF_FFFC;
                1:       rpc = $urandom_range(0, 255);
                default: rpc = $urandom;
            endcase
            step($urandom_range(0, 7) == 0, rpc, $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
